pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle PC controller that owns the architectural PC register and drives the select code of the next-PC unit.
- Per instruction it sequences fetch, waits for the instruction memory handshake, then commits the next-PC result.
- Arbitrates external interrupts against normal flow at instruction boundaries, captures EPC, and manages the EXL flag for ERET.
- Sits between the decoder, the instruction-memory port and the next-PC unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- fetch_req  output  1  request an instruction fetch at address pc
- imem_ready  input  1  instruction memory data valid; sampled only while fetch_req=1
- dec_code  input  4  next-PC code from the decoder: 0 IR, 1 BEQ, 2 BNE, 3 BGTZ, 4 BGEZ, 5 BLTZ, 6 BLEZ, 7 J/JAL, 8 JR/JALR, 9 INT, 10 ERET
- stall  input  1  hazard/multicycle-unit hold request during EXEC
- npc_in  input  32  next-PC result returned by the next-PC unit
- npc_code  output  4  select code driven to the next-PC unit (same encoding as dec_code)
- pc  output  32  architectural PC register
- int_req  input  1  level interrupt request
- int_en  input  1  global interrupt enable
- epc_we  input  1  software EPC write (mtc0)
- epc_wdata  input  32  software EPC write data
- epc  output  32  exception PC register, fed to the next-PC unit
- exl  output  1  exception level; 1 while in the handler
- int_ack  output  1  one-cycle pulse on interrupt entry
- instret  output  32  retired-instruction counter

Behaviour:
- Reset, when rst=1 at a clock edge, overriding everything including mid-fetch and mid-EXEC:
  - pc=RESET_PC, epc=0, exl=0, int_ack=0, instret=0, state=FETCH.
  - Outputs take these values in the cycle after that edge.
- States: FETCH, EXEC, INT.
- FETCH:
  - fetch_req=1 and npc_code=0.
  - imem_ready=1 goes to EXEC; otherwise stay in FETCH with no timeout.
- EXEC:
  - fetch_req=0.
  - npc_code=dec_code. Codes 9 and 11..15 are forced to 0, so software cannot enter the interrupt vector.
  - stall=1: hold in EXEC; no register update except software EPC writes.
  - stall=0: pc<=npc_in and instret<=instret+1, wrapping at 2^32.
  - If dec_code=10 (ERET), also exl<=0.
  - Interrupt check, evaluated only when stall=0 and the code is not ERET: if int_req && int_en && !exl, then epc<=npc_in (the resume address, never the retiring instruction's pc) and go to INT. Otherwise go to FETCH.
- INT (exactly one cycle):
  - npc_code=9, fetch_req=0, int_ack=1.
  - pc<=npc_in (the next-PC unit supplies 32'h0000_4180), exl<=1, then go to FETCH.
  - instret does not increment.
- int_ack is 1 only in INT, 0 in all other states.
- EPC write priority: interrupt capture beats epc_we in the same cycle. Otherwise epc<=epc_wdata on epc_we in any state.
- ERET and a pending interrupt in the same EXEC: ERET completes, exl clears, no interrupt entry that cycle. The interrupt is taken at the next instruction boundary.
- Interrupts are ignored while exl=1 or int_en=0. int_req is level-sensitive; nothing is latched.
- pc and epc are plain registers; no alignment checking.

Test Plan:
- Reset then FETCH with imem_ready low for 3 cycles, dec_code=0, npc_in=32'h3004 → pc stays 32'h3000 while fetch_req=1 for 4 cycles; pc=32'h3004 and instret=1 after EXEC.
- EXEC with dec_code=1 (BEQ), npc_in=32'h3040 → npc_code=1 during EXEC; pc=32'h3040 after.
- stall=1 for 2 EXEC cycles, then 0 → pc and instret unchanged during the stall; single commit after.
- int_req=1, int_en=1, exl=0, dec_code=0, npc_in=32'h3008 → epc=32'h3008; INT cycle with npc_code=9 and int_ack pulse; pc=32'h4180; exl=1.
- In handler: int_req held high → no re-entry. Then dec_code=10, npc_in=32'h3008 → pc=32'h3008, exl=0, no INT in that cycle; interrupt taken after the next instruction.
- epc_we=1 coincident with interrupt capture → epc takes npc_in, not epc_wdata. rst=1 during EXEC → pc=32'h3000, exl=0, state FETCH.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: sequences FETCH -> EXEC (-> INT) per instruction,
// owns the architectural PC, EPC, EXL and the retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  input  logic        imem_ready,
  input  logic [3:0]  dec_code,
  input  logic        stall,
  input  logic [31:0] npc_in,
  output logic [3:0]  npc_code,
  output logic [31:0] pc,
  input  logic        int_req,
  input  logic        int_en,
  input  logic        epc_we,
  input  logic [31:0] epc_wdata,
  output logic [31:0] epc,
  output logic        exl,
  output logic        int_ack,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    INT   = 2'd2
  } state_t;

  localparam logic [3:0] CODE_IR   = 4'd0;
  localparam logic [3:0] CODE_INT  = 4'd9;
  localparam logic [3:0] CODE_ERET = 4'd10;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_exl;
  logic [31:0] r_instret;

  logic        w_commit;
  logic        w_eret;
  logic        w_take_int;
  logic [3:0]  w_exec_code;

  // Software may never select the interrupt vector or an undefined code.
  always_comb begin
    w_exec_code = dec_code;
    if (dec_code == CODE_INT || dec_code > CODE_ERET) begin
      w_exec_code = CODE_IR;
    end
  end

  assign w_commit   = (r_state == EXEC) && !stall;
  assign w_eret     = (dec_code == CODE_ERET);
  assign w_take_int = w_commit && !w_eret && int_req && int_en && !r_exl;

  always_comb begin
    w_state_next = r_state;
    fetch_req    = 1'b0;
    npc_code     = CODE_IR;
    int_ack      = 1'b0;
    case (r_state)
      FETCH: begin
        fetch_req = 1'b1;
        if (imem_ready) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        npc_code = w_exec_code;
        if (!stall) begin
          w_state_next = w_take_int ? INT : FETCH;
        end
      end
      INT: begin
        npc_code     = CODE_INT;
        int_ack      = 1'b1;
        w_state_next = FETCH;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_epc     <= 32'h0;
      r_exl     <= 1'b0;
      r_instret <= 32'h0;
    end else begin
      r_state <= w_state_next;

      if (w_commit) begin
        r_pc      <= npc_in;
        r_instret <= r_instret + 32'd1;
        if (w_eret) begin
          r_exl <= 1'b0;
        end
      end else if (r_state == INT) begin
        r_pc  <= npc_in;
        r_exl <= 1'b1;
      end

      // Interrupt capture wins over a same-cycle mtc0 to EPC.
      if (w_take_int) begin
        r_epc <= npc_in;
      end else if (epc_we) begin
        r_epc <= epc_wdata;
      end
    end
  end

  assign pc      = r_pc;
  assign epc     = r_epc;
  assign exl     = r_exl;
  assign instret = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table stepped one clock per entry,
// plus a hand-written interrupt-entry sequence with a bounded wait.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        imem_ready;
  logic [3:0]  dec_code;
  logic        stall;
  logic [31:0] npc_in;
  logic [3:0]  npc_code;
  logic [31:0] pc;
  logic        int_req;
  logic        int_en;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic [31:0] epc;
  logic        exl;
  logic        int_ack;
  logic [31:0] instret;

  int checks;
  int errors;

  pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .imem_ready (imem_ready),
    .dec_code   (dec_code),
    .stall      (stall),
    .npc_in     (npc_in),
    .npc_code   (npc_code),
    .pc         (pc),
    .int_req    (int_req),
    .int_en     (int_en),
    .epc_we     (epc_we),
    .epc_wdata  (epc_wdata),
    .epc        (epc),
    .exl        (exl),
    .int_ack    (int_ack),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [3:0]  dec;
    logic        stall;
    logic [31:0] npc;
    logic        irq;
    logic        ien;
    logic        we;
    logic [31:0] wd;
    logic        xFr;
    logic [3:0]  xCode;
    logic [31:0] xPc;
    logic [31:0] xEpc;
    logic        xExl;
    logic        xAck;
    logic [31:0] xRet;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst_i, input logic rdy_i, input logic [3:0] dec_i, input logic stall_i,
    input logic [31:0] npc_i, input logic irq_i, input logic ien_i, input logic we_i,
    input logic [31:0] wd_i, input logic fr_i, input logic [3:0] code_i,
    input logic [31:0] pc_i, input logic [31:0] epc_i, input logic exl_i,
    input logic ack_i, input logic [31:0] ret_i);
    vec_t v;
    v.rst = rst_i;  v.rdy = rdy_i;   v.dec = dec_i;   v.stall = stall_i;
    v.npc = npc_i;  v.irq = irq_i;   v.ien = ien_i;   v.we = we_i;   v.wd = wd_i;
    v.xFr = fr_i;   v.xCode = code_i; v.xPc = pc_i;   v.xEpc = epc_i;
    v.xExl = exl_i; v.xAck = ack_i;  v.xRet = ret_i;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    imem_ready = v.rdy;
    dec_code   = v.dec;
    stall      = v.stall;
    npc_in     = v.npc;
    int_req    = v.irq;
    int_en     = v.ien;
    epc_we     = v.we;
    epc_wdata  = v.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d fetch_req", idx), {31'h0, fetch_req}, {31'h0, v.xFr});
    checkOutput($sformatf("v%0d npc_code", idx), {28'h0, npc_code}, {28'h0, v.xCode});
    checkOutput($sformatf("v%0d pc", idx), pc, v.xPc);
    checkOutput($sformatf("v%0d epc", idx), epc, v.xEpc);
    checkOutput($sformatf("v%0d exl", idx), {31'h0, exl}, {31'h0, v.xExl});
    checkOutput($sformatf("v%0d int_ack", idx), {31'h0, int_ack}, {31'h0, v.xAck});
    checkOutput($sformatf("v%0d instret", idx), instret, v.xRet);
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    rst = 1'b1; imem_ready = 1'b0; dec_code = 4'd0; stall = 1'b0;
    npc_in = 32'h0; int_req = 1'b0; int_en = 1'b0; epc_we = 1'b0; epc_wdata = 32'h0;

    //             rst rdy dec stl npc            irq ien we wd              fr code pc             epc            exl ack ret
    vecs.push_back(mk(1, 0, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          0, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3004, 32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 1, 1,  0, 32'h0000_3040, 0, 0, 0, 32'h0,          0, 1,  32'h0000_3004, 32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 0, 1,  0, 32'h0000_3040, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3040, 32'h0,         0, 0, 2));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_3044, 0, 0, 0, 32'h0,          0, 0,  32'h0000_3040, 32'h0,         0, 0, 2));
    vecs.push_back(mk(0, 0, 0,  1, 32'h0000_3044, 0, 0, 0, 32'h0,          0, 0,  32'h0000_3040, 32'h0,         0, 0, 2));
    vecs.push_back(mk(0, 0, 0,  1, 32'h0000_3044, 0, 0, 0, 32'h0,          0, 0,  32'h0000_3040, 32'h0,         0, 0, 2));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3044, 0, 0, 0, 32'h0,          1, 0,  32'h0000_3044, 32'h0,         0, 0, 3));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_3008, 1, 1, 0, 32'h0,          0, 0,  32'h0000_3044, 32'h0,         0, 0, 3));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3008, 1, 1, 1, 32'hDEAD_BEEF,  0, 9,  32'h0000_3008, 32'h0000_3008, 0, 1, 4));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_4180, 1, 1, 0, 32'h0,          1, 0,  32'h0000_4180, 32'h0000_3008, 1, 0, 4));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_4184, 1, 1, 0, 32'h0,          0, 0,  32'h0000_4180, 32'h0000_3008, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_4184, 1, 1, 0, 32'h0,          1, 0,  32'h0000_4184, 32'h0000_3008, 1, 0, 5));
    vecs.push_back(mk(0, 1, 10, 0, 32'h0000_3008, 1, 1, 0, 32'h0,          0, 10, 32'h0000_4184, 32'h0000_3008, 1, 0, 5));
    vecs.push_back(mk(0, 0, 10, 0, 32'h0000_3008, 1, 1, 0, 32'h0,          1, 0,  32'h0000_3008, 32'h0000_3008, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_300C, 1, 1, 0, 32'h0,          0, 0,  32'h0000_3008, 32'h0000_3008, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_300C, 1, 1, 0, 32'h0,          0, 9,  32'h0000_300C, 32'h0000_300C, 0, 1, 7));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_4180, 1, 1, 0, 32'h0,          1, 0,  32'h0000_4180, 32'h0000_300C, 1, 0, 7));
    vecs.push_back(mk(0, 1, 9,  0, 32'h0000_4180, 0, 1, 0, 32'h0,          0, 0,  32'h0000_4180, 32'h0000_300C, 1, 0, 7));
    vecs.push_back(mk(0, 0, 12, 1, 32'h0000_4180, 0, 1, 0, 32'h0,          0, 0,  32'h0000_4180, 32'h0000_300C, 1, 0, 7));
    vecs.push_back(mk(0, 0, 12, 1, 32'h0000_4180, 0, 1, 1, 32'h1234_5678,  0, 0,  32'h0000_4180, 32'h1234_5678, 1, 0, 7));
    vecs.push_back(mk(1, 0, 12, 1, 32'h0000_4180, 0, 1, 0, 32'h0,          1, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0, 32'h0000_3004, 1, 0, 0, 32'h0,          0, 0,  32'h0000_3000, 32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 1, 0, 0, 32'h0,          1, 0,  32'h0000_3004, 32'h0,         0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 32'h0000_3004, 0, 0, 1, 32'hAAAA_5555,  1, 0,  32'h0000_3004, 32'hAAAA_5555, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Reset mid-fetch, then let an interrupt be taken on the first boundary.
    rst = 1'b1; imem_ready = 1'b1; dec_code = 4'd0; stall = 1'b0;
    npc_in = 32'h0000_3010; int_req = 1'b1; int_en = 1'b1; epc_we = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("seq reset pc", pc, 32'h0000_3000);
    checkOutput("seq reset fetch_req", {31'h0, fetch_req}, 32'h1);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (int_ack) found = 1'b1;
    end
    checkOutput("seq int_ack seen", {31'h0, found}, 32'h1);
    checkOutput("seq epc capture", epc, 32'h0000_3010);
    checkOutput("seq npc_code int", {28'h0, npc_code}, 32'h9);
    npc_in = 32'h0000_4180;
    @(posedge clk);
    #1;
    checkOutput("seq int_ack pulse", {31'h0, int_ack}, 32'h0);
    checkOutput("seq handler pc", pc, 32'h0000_4180);
    checkOutput("seq handler exl", {31'h0, exl}, 32'h1);
    checkOutput("seq instret", instret, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
